// File: rtl/div_share_arbiter_pkg.sv
// Shared definitions for the divider-sharing arbiter: FSM encoding and datapath widths.
package div_share_arbiter_pkg;

   localparam int OPW = 48;
   localparam int QW  = 18;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_LAUNCH,
      ST_WAIT,
      ST_ZERR,
      ST_RESP
   } state_t;

endpackage

// File: rtl/div_share_arbiter_rr_pick.sv
// Combinational round-robin picker: first asserted request strictly after the pointer, wrapping.
module div_share_arbiter_rr_pick #(
   parameter int NREQ = 4,
   parameter int PW   = 2
) (
   input  logic [NREQ-1:0] i_req,
   input  logic [PW-1:0]   i_ptr,
   output logic [PW-1:0]   o_grant,
   output logic            o_any
);

   int w_idx;

   always_comb begin
      o_grant = '0;
      o_any   = 1'b0;
      w_idx   = 0;
      for (int k = 1; k <= NREQ; k++) begin
         w_idx = (int'(i_ptr) + k) % NREQ;
         if (!o_any && i_req[w_idx[PW-1:0]]) begin
            o_grant = w_idx[PW-1:0];
            o_any   = 1'b1;
         end
      end
   end

endmodule

// File: rtl/div_share_arbiter.sv
// Shares one iterative divider core between NREQ requesters with round-robin arbitration,
// divide-by-zero bypass and a watchdog that aborts jobs the core never finishes.
module div_share_arbiter
   import div_share_arbiter_pkg::*;
#(
   parameter int NREQ    = 4,
   parameter int TIMEOUT = 255,
   parameter int CW      = 8
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic [NREQ-1:0]      req_valid,
   output logic [NREQ-1:0]      req_ready,
   input  logic [OPW*NREQ-1:0]  req_n,
   input  logic [OPW*NREQ-1:0]  req_d,
   output logic [NREQ-1:0]      rsp_valid,
   output logic [QW-1:0]        rsp_q,
   output logic                 rsp_err,
   output logic                 busy,
   output logic [OPW-1:0]       div_n,
   output logic [OPW-1:0]       div_d,
   output logic                 div_sync_in,
   input  logic [QW-1:0]        div_q,
   input  logic                 div_sync_out
);

   localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;

   state_t          r_state;
   state_t          w_next;
   logic [PW-1:0]   r_rrPtr;
   logic [PW-1:0]   r_owner;
   logic [CW-1:0]   r_watchdog;
   logic [OPW-1:0]  r_divN;
   logic [OPW-1:0]  r_divD;
   logic [QW-1:0]   r_rspQ;
   logic            r_rspErr;

   logic [PW-1:0]   w_grant;
   logic            w_any;
   logic            w_accept;
   logic            w_timeout;
   logic [OPW-1:0]  w_reqN [NREQ];
   logic [OPW-1:0]  w_reqD [NREQ];
   logic [OPW-1:0]  w_selN;
   logic [OPW-1:0]  w_selD;

   for (genvar i = 0; i < NREQ; i++) begin : g_unpack
      assign w_reqN[i] = req_n[OPW*i +: OPW];
      assign w_reqD[i] = req_d[OPW*i +: OPW];
   end

   div_share_arbiter_rr_pick #(
      .NREQ (NREQ),
      .PW   (PW)
   ) u_rrPick (
      .i_req   (req_valid),
      .i_ptr   (r_rrPtr),
      .o_grant (w_grant),
      .o_any   (w_any)
   );

   assign w_selN    = w_reqN[w_grant];
   assign w_selD    = w_reqD[w_grant];
   assign w_timeout = (r_watchdog == CW'(TIMEOUT));
   // Accepts are suppressed while reset is held so every output reads 0 during reset.
   assign w_accept  = (r_state == ST_IDLE) && w_any && !rst;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state <= ST_IDLE;
      end else begin
         r_state <= w_next;
      end
   end

   always_comb begin
      w_next = r_state;
      unique case (r_state)
         ST_IDLE:   if (w_any) w_next = (w_selD != '0) ? ST_LAUNCH : ST_ZERR;
         ST_LAUNCH: w_next = ST_WAIT;
         ST_WAIT:   if (div_sync_out || w_timeout) w_next = ST_RESP;
         ST_ZERR:   w_next = ST_RESP;
         ST_RESP:   w_next = ST_IDLE;
         default:   w_next = ST_IDLE;
      endcase
   end

   // A done strobe wins over a simultaneous watchdog expiry; strobes outside WAIT are ignored.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_rrPtr    <= PW'(NREQ - 1);
         r_owner    <= '0;
         r_watchdog <= '0;
         r_divN     <= '0;
         r_divD     <= '0;
         r_rspQ     <= '0;
         r_rspErr   <= 1'b0;
      end else begin
         unique case (r_state)
            ST_IDLE: begin
               if (w_any) begin
                  r_divN  <= w_selN;
                  r_divD  <= w_selD;
                  r_owner <= w_grant;
                  r_rrPtr <= w_grant;
               end
            end
            ST_LAUNCH: r_watchdog <= '0;
            ST_WAIT: begin
               r_watchdog <= r_watchdog + CW'(1);
               if (div_sync_out) begin
                  r_rspQ   <= div_q;
                  r_rspErr <= 1'b0;
               end else if (w_timeout) begin
                  r_rspQ   <= '0;
                  r_rspErr <= 1'b1;
               end
            end
            ST_ZERR: begin
               r_rspQ   <= '0;
               r_rspErr <= 1'b1;
            end
            default: ;
         endcase
      end
   end

   assign req_ready   = w_accept ? (NREQ'(1) << w_grant) : '0;
   assign rsp_valid   = (r_state == ST_RESP) ? (NREQ'(1) << r_owner) : '0;
   assign div_sync_in = (r_state == ST_LAUNCH);
   assign busy        = (r_state != ST_IDLE);
   assign div_n       = r_divN;
   assign div_d       = r_divD;
   assign rsp_q       = r_rspQ;
   assign rsp_err     = r_rspErr;

endmodule
